// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and constants for the two-source PCIe TX arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package pcie_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int TUSER_WIDTH = 4;
    localparam int PRIO_RR     = 0;
    localparam int PRIO_FIXED  = 1;

endpackage

// File: rtl/pcie_tx_arb_pick.sv
// Next-grant picker: one-hot grant from two requests, round-robin or fixed priority.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is used.
module pcie_tx_arb_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       prio_mode,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (prio_mode) begin
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
        end else begin
            // On contention the port that did not win last time is served.
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic arbiter sharing the PCIe core AXIS TX port between two TLP sources; PCIE_TX_ARB_STATS_EN adds counters.
// Latency: ack one cycle after req is sampled; data path is a zero-latency mux on the held grant.
// Backpressure: m_tready passes straight to the granted source only; ungranted sources always see tready=0.
module pcie_tx_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int  C_DATA_WIDTH = 64,
    parameter int  PRIO_MODE    = PRIO_RR,
    parameter int  CNT_WIDTH    = 32,
    localparam int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst_n,

    input  logic                    s0_req,
    output logic                    s0_ack,
    input  logic                    s0_tvalid,
    input  logic                    s0_tlast,
    input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
    input  logic [C_DATA_WIDTH-1:0] s0_tdata,
    input  logic [TUSER_WIDTH-1:0]  s0_tuser,
    output logic                    s0_tready,

    input  logic                    s1_req,
    output logic                    s1_ack,
    input  logic                    s1_tvalid,
    input  logic                    s1_tlast,
    input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
    input  logic [C_DATA_WIDTH-1:0] s1_tdata,
    input  logic [TUSER_WIDTH-1:0]  s1_tuser,
    output logic                    s1_tready,

    output logic                    m_tvalid,
    output logic                    m_tlast,
    output logic [KEEP_WIDTH-1:0]   m_tkeep,
    output logic [C_DATA_WIDTH-1:0] m_tdata,
    output logic [TUSER_WIDTH-1:0]  m_tuser,
    input  logic                    m_tready
`ifdef PCIE_TX_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]    stat_pkt0,
    output logic [CNT_WIDTH-1:0]    stat_pkt1,
    output logic [CNT_WIDTH-1:0]    stat_conflict
`endif
);

    if (C_DATA_WIDTH % 8 != 0 || C_DATA_WIDTH < 8 || CNT_WIDTH < 1) begin : g_param_check
        $error("pcie_tx_arbiter: C_DATA_WIDTH must be a multiple of 8 and CNT_WIDTH >= 1");
    end

    arb_state_t state;
    logic       last_grant;
    logic [1:0] req;
    logic [1:0] grant;
    logic       pkt_done;
    logic       decide;

    assign req      = {s1_req, s0_req};
    assign pkt_done = m_tvalid & m_tready & m_tlast;
    // A new grant is chosen only from IDLE or on the edge that retires a TLP.
    assign decide   = (state == IDLE) | pkt_done;

    pcie_tx_arb_pick u_pick (
        .req        (req),
        .last_grant (last_grant),
        .prio_mode  (PRIO_MODE == PRIO_FIXED),
        .grant      (grant)
    );

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            s0_ack     <= 1'b0;
            s1_ack     <= 1'b0;
        end else if (decide) begin
            if (grant[0]) begin
                state      <= GNT0;
                last_grant <= 1'b0;
                s0_ack     <= 1'b1;
                s1_ack     <= 1'b0;
            end else if (grant[1]) begin
                state      <= GNT1;
                last_grant <= 1'b1;
                s0_ack     <= 1'b0;
                s1_ack     <= 1'b1;
            end else begin
                state      <= IDLE;
                s0_ack     <= 1'b0;
                s1_ack     <= 1'b0;
            end
        end
    end

    // Acks are mutually exclusive, so gating each source and OR-ing is a clean mux.
    assign m_tvalid  = (s0_tvalid & s0_ack) | (s1_tvalid & s1_ack);
    assign m_tlast   = (s0_tlast  & s0_ack) | (s1_tlast  & s1_ack);
    assign m_tkeep   = (s0_tkeep & {KEEP_WIDTH{s0_ack}})   | (s1_tkeep & {KEEP_WIDTH{s1_ack}});
    assign m_tdata   = (s0_tdata & {C_DATA_WIDTH{s0_ack}}) | (s1_tdata & {C_DATA_WIDTH{s1_ack}});
    assign m_tuser   = (s0_tuser & {TUSER_WIDTH{s0_ack}})  | (s1_tuser & {TUSER_WIDTH{s1_ack}});
    assign s0_tready = m_tready & s0_ack;
    assign s1_tready = m_tready & s1_ack;

`ifdef PCIE_TX_ARB_STATS_EN
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            stat_pkt0     <= '0;
            stat_pkt1     <= '0;
            stat_conflict <= '0;
        end else begin
            if (pkt_done & s0_ack) begin
                stat_pkt0 <= stat_pkt0 + CNT_WIDTH'(1);
            end
            if (pkt_done & s1_ack) begin
                stat_pkt1 <= stat_pkt1 + CNT_WIDTH'(1);
            end
            if (decide & s0_req & s1_req) begin
                stat_conflict <= stat_conflict + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule
